// File: rtl/dec_arb_if.sv
// Requester, decoder and result bus of the two-port decoder arbiter.
// The arbiter takes the slave view; the bench and decoder side take the master view.
interface dec_arb_if #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_PARITY_WIDTH   = 6
);
  logic                          req0_valid, req1_valid;
  logic                          req0_ready, req1_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] req0_data, req1_data;
  logic [MAX_PARITY_WIDTH-1:0]   req0_syn, req1_syn;
  logic [1:0]                    req0_mod, req1_mod;
  logic [MAX_CODEWORD_WIDTH-1:0] dec_data;
  logic [MAX_PARITY_WIDTH-1:0]   dec_syn;
  logic [1:0]                    dec_mod;
  logic [MAX_CODEWORD_WIDTH-1:0] dec_data_out;
  logic [1:0]                    dec_num_err;
  logic                          res_valid, res_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] res_data;
  logic [1:0]                    res_err;
  logic                          res_id;
  logic                          cnt_clr;
  logic [15:0]                   cnt_err1, cnt_err2;

  modport slave (
    input  req0_valid, req0_data, req0_syn, req0_mod,
    input  req1_valid, req1_data, req1_syn, req1_mod,
    input  dec_data_out, dec_num_err, res_ready, cnt_clr,
    output req0_ready, req1_ready, dec_data, dec_syn, dec_mod,
    output res_valid, res_data, res_err, res_id, cnt_err1, cnt_err2
  );

  modport master (
    output req0_valid, req0_data, req0_syn, req0_mod,
    output req1_valid, req1_data, req1_syn, req1_mod,
    output dec_data_out, dec_num_err, res_ready, cnt_clr,
    input  req0_ready, req1_ready, dec_data, dec_syn, dec_mod,
    input  res_valid, res_data, res_err, res_id, cnt_err1, cnt_err2
  );
endinterface

// File: rtl/dec_arb.sv
// Round-robin arbiter sharing one registered decoder between two requesters,
// one transaction in flight, with saturating error-statistics counters.
module dec_arb #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_PARITY_WIDTH   = 6
) (
  input logic      clk,
  input logic      rst,
  dec_arb_if.slave bus
);
  localparam int CW = MAX_CODEWORD_WIDTH;
  localparam int PW = MAX_PARITY_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  typedef struct packed {
    logic [CW-1:0] data;
    logic [PW-1:0] syn;
    logic [1:0]    mod;
    logic          id;
  } req_t;

  state_t        state, nxt;
  req_t          lat, req0, req1;
  logic          pri, gnt0, gnt1, hs;
  logic [CW-1:0] res_data_q;
  logic [1:0]    res_err_q;
  logic          res_id_q;
  logic [15:0]   err1_q, err2_q;

  assign req0 = {bus.req0_data, bus.req0_syn, bus.req0_mod, 1'b0};
  assign req1 = {bus.req1_data, bus.req1_syn, bus.req1_mod, 1'b1};
  assign hs   = (state == RESP) && bus.res_ready;

  // pri=1 means requester 1 wins a tie; a lone valid always wins.
  always_comb begin
    nxt  = state;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: if (!rst) begin
        if (bus.req0_valid && (!bus.req1_valid || !pri)) gnt0 = 1'b1;
        else if (bus.req1_valid)                         gnt1 = 1'b1;
        if (gnt0 || gnt1) nxt = ISSUE;
      end
      ISSUE:   nxt = CAPT;
      CAPT:    nxt = RESP;
      RESP:    if (bus.res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pri        <= 1'b0;
      lat        <= '0;
      res_data_q <= '0;
      res_err_q  <= 2'b00;
      res_id_q   <= 1'b0;
      err1_q     <= '0;
      err2_q     <= '0;
    end else begin
      state <= nxt;
      if (gnt0 || gnt1) begin
        lat <= gnt0 ? req0 : req1;
        pri <= gnt0;
      end
      // Illegal mode bypasses the decoder result but keeps the same latency.
      if (state == CAPT) begin
        res_data_q <= (lat.mod == 2'b11) ? lat.data : bus.dec_data_out;
        res_err_q  <= (lat.mod == 2'b11) ? 2'b11    : bus.dec_num_err;
        res_id_q   <= lat.id;
      end
      if (bus.cnt_clr) begin
        err1_q <= '0;
        err2_q <= '0;
      end else if (hs) begin
        if (res_err_q == 2'b01 && err1_q != 16'hFFFF) err1_q <= err1_q + 16'd1;
        if (res_err_q == 2'b10 && err2_q != 16'hFFFF) err2_q <= err2_q + 16'd1;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.dec_data   = lat.data;
  assign bus.dec_syn    = lat.syn;
  assign bus.dec_mod    = lat.mod;
  assign bus.res_valid  = (state == RESP);
  assign bus.res_data   = res_data_q;
  assign bus.res_err    = res_err_q;
  assign bus.res_id     = res_id_q;
  assign bus.cnt_err1   = err1_q;
  assign bus.cnt_err2   = err2_q;
endmodule

// File: tb/tb_dec_arb.sv
// Directed bench for dec_arb with a registered toy decoder: nonzero syndrome
// flips bit syn[4:0]; syn[5] marks the word uncorrectable.
module tb_dec_arb;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dec_arb_if #(.MAX_CODEWORD_WIDTH(32), .MAX_PARITY_WIDTH(6)) bus ();

  dec_arb #(.MAX_CODEWORD_WIDTH(32), .MAX_PARITY_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always @(posedge clk) begin
    bus.dec_data_out <= (bus.dec_syn == 6'd0) ? bus.dec_data
                                              : bus.dec_data ^ (32'h1 << bus.dec_syn[4:0]);
    bus.dec_num_err  <= (bus.dec_syn == 6'd0) ? 2'd0 : (bus.dec_syn[5] ? 2'd2 : 2'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drive a single request into IDLE and advance to its RESP cycle.
  task automatic issue(input logic id, input logic [31:0] d, input logic [5:0] s,
                       input logic [1:0] m);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_syn = s; bus.req1_mod = m;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_syn = s; bus.req0_mod = m;
    end
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    step();
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got=%b exp=0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got=%b exp=0", bus.req1_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL rst_res_data got=%h exp=0", bus.res_data); end
    checks++; if (bus.res_err !== 2'b00 || bus.res_id !== 1'b0) begin errors++; $display("FAIL rst_res_err_id got=%b/%b exp=00/0", bus.res_err, bus.res_id); end
    checks++; if (bus.cnt_err1 !== 16'h0 || bus.cnt_err2 !== 16'h0) begin errors++; $display("FAIL rst_counters got=%h/%h exp=0/0", bus.cnt_err1, bus.cnt_err2); end
    checks++; if ({bus.dec_data, bus.dec_syn, bus.dec_mod} !== 40'h0) begin errors++; $display("FAIL rst_dec_regs got=%h/%h/%b exp=0", bus.dec_data, bus.dec_syn, bus.dec_mod); end
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_data = 32'h1234_5678; bus.req0_syn = 6'h03; bus.req0_mod = 2'b01;
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    for (int c = 1; c <= 2; c++) begin
      step(); #1;
      checks++; if (bus.req0_ready !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_busy_c%0d ready=%b valid=%b exp=0/0", c, bus.req0_ready, bus.res_valid); end
    end
    checks++; if (bus.dec_data !== 32'h1234_5678 || bus.dec_syn !== 6'h03 || bus.dec_mod !== 2'b01) begin errors++; $display("FAIL single_dec_bus got=%h/%h/%b exp=12345678/03/01", bus.dec_data, bus.dec_syn, bus.dec_mod); end
    step();
    bus.req0_valid = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h1234_5670 || bus.res_err !== 2'b01 || bus.res_id !== 1'b0) begin errors++; $display("FAIL single_result got=%h/%b/%b exp=12345670/01/0", bus.res_data, bus.res_err, bus.res_id); end
    step(); #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.cnt_err1 !== 16'd1 || bus.cnt_err2 !== 16'd0) begin errors++; $display("FAIL single_after valid=%b cnt=%0d/%0d exp=0 1/0", bus.res_valid, bus.cnt_err1, bus.cnt_err2); end
  endtask

  task automatic test_contention();
    logic er0, er1, ev, eid;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 32'h0000_00F0; bus.req0_syn = 6'h01; bus.req0_mod = 2'b01;
    bus.req1_valid = 1'b1; bus.req1_data = 32'hA5A5_0000; bus.req1_syn = 6'h22; bus.req1_mod = 2'b00;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      er0 = (c % 8 == 0); er1 = (c % 8 == 4); ev = (c % 4 == 3); eid = (c % 8 == 7);
      #1;
      checks++; if (bus.req0_ready !== er0 || bus.req1_ready !== er1) begin errors++; $display("FAIL cont_grant_c%0d got=%b%b exp=%b%b", c, bus.req0_ready, bus.req1_ready, er0, er1); end
      checks++; if (bus.res_valid !== ev) begin errors++; $display("FAIL cont_valid_c%0d got=%b exp=%b", c, bus.res_valid, ev); end
      if (ev) begin
        checks++; if (bus.res_id !== eid) begin errors++; $display("FAIL cont_id_c%0d got=%b exp=%b", c, bus.res_id, eid); end
        checks++; if (bus.res_data !== (eid ? 32'hA5A5_0004 : 32'h0000_00F2) || bus.res_err !== (eid ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_result_c%0d got=%h/%b id=%b", c, bus.res_data, bus.res_err, eid); end
      end
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    checks++; if (bus.cnt_err1 !== 16'd2 || bus.cnt_err2 !== 16'd2) begin errors++; $display("FAIL cont_counters got=%0d/%0d exp=2/2", bus.cnt_err1, bus.cnt_err2); end
    step();
  endtask

  task automatic test_back_to_back_backpressure();
    logic ev;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 32'h0000_00F0; bus.req0_syn = 6'h01; bus.req0_mod = 2'b01;
    bus.req1_valid = 1'b1; bus.req1_data = 32'hA5A5_0000; bus.req1_syn = 6'h22; bus.req1_mod = 2'b00;
    for (int c = 0; c < 10; c++) begin
      bus.res_ready = (c >= 8);
      ev = (c >= 3 && c <= 8);
      #1;
      checks++; if (bus.req0_ready !== (c == 0) || bus.req1_ready !== (c == 9)) begin errors++; $display("FAIL bp_grant_c%0d got=%b%b", c, bus.req0_ready, bus.req1_ready); end
      checks++; if (bus.res_valid !== ev) begin errors++; $display("FAIL bp_valid_c%0d got=%b exp=%b", c, bus.res_valid, ev); end
      if (ev) begin
        checks++; if (bus.res_data !== 32'h0000_00F2 || bus.res_err !== 2'b01 || bus.res_id !== 1'b0) begin errors++; $display("FAIL bp_stable_c%0d got=%h/%b/%b exp=000000f2/01/0", c, bus.res_data, bus.res_err, bus.res_id); end
      end
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    step();
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 || bus.res_err !== 2'b10) begin errors++; $display("FAIL bp_second valid=%b id=%b err=%b exp=1/1/10", bus.res_valid, bus.res_id, bus.res_err); end
    step();
  endtask

  task automatic test_illegal_mode();
    do_reset();
    bus.res_ready = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_data = 32'hDEAD_BEEF; bus.req1_syn = 6'h05; bus.req1_mod = 2'b11;
    #1;
    checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL ill_grant got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    #1;
    checks++; if (bus.dec_mod !== 2'b11 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL ill_issue mod=%b valid=%b exp=11/0", bus.dec_mod, bus.res_valid); end
    step();
    step(); #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hDEAD_BEEF || bus.res_err !== 2'b11 || bus.res_id !== 1'b1) begin errors++; $display("FAIL ill_result got=%b %h/%b/%b exp=1 deadbeef/11/1", bus.res_valid, bus.res_data, bus.res_err, bus.res_id); end
    step(); #1;
    checks++; if (bus.cnt_err1 !== 16'd0 || bus.cnt_err2 !== 16'd0) begin errors++; $display("FAIL ill_counters got=%0d/%0d exp=0/0", bus.cnt_err1, bus.cnt_err2); end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    bus.res_ready = 1'b1;
    dut.err2_q = 16'hFFFE;
    issue(1'b0, 32'h0, 6'h21, 2'b01);
    #1;
    checks++; if (bus.res_err !== 2'b10 || bus.res_data !== 32'h2) begin errors++; $display("FAIL sat_result got=%h/%b exp=00000002/10", bus.res_data, bus.res_err); end
    step(); #1;
    checks++; if (bus.cnt_err2 !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", bus.cnt_err2); end
    issue(1'b0, 32'h0, 6'h21, 2'b01);
    step(); #1;
    checks++; if (bus.cnt_err2 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", bus.cnt_err2); end
    issue(1'b0, 32'h0, 6'h01, 2'b01);
    bus.cnt_clr = 1'b1;
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_err !== 2'b01) begin errors++; $display("FAIL clr_result valid=%b err=%b exp=1/01", bus.res_valid, bus.res_err); end
    step();
    bus.cnt_clr = 1'b0;
    #1;
    checks++; if (bus.cnt_err1 !== 16'd0 || bus.cnt_err2 !== 16'd0) begin errors++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", bus.cnt_err1, bus.cnt_err2); end
  endtask

  task automatic test_reset_in_capt();
    bus.res_ready = 1'b1;
    issue(1'b0, 32'h100, 6'h02, 2'b01);
    step(); #1;
    checks++; if (bus.cnt_err1 !== 16'd1) begin errors++; $display("FAIL rcapt_pre got=%0d exp=1", bus.cnt_err1); end
    bus.req0_valid = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rcapt_ready_in_rst got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.cnt_err1 !== 16'd0 || bus.cnt_err2 !== 16'd0) begin errors++; $display("FAIL rcapt_after valid=%b cnt=%0d/%0d exp=0 0/0", bus.res_valid, bus.cnt_err1, bus.cnt_err2); end
    checks++; if (bus.dec_data !== 32'h0) begin errors++; $display("FAIL rcapt_dec_data got=%h exp=0", bus.dec_data); end
    bus.req1_valid = 1'b1; bus.req1_data = 32'h55; bus.req1_syn = 6'h00; bus.req1_mod = 2'b00;
    #1;
    checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rcapt_regrant got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rcapt_no_stale got=%b exp=0", bus.res_valid); end
    step();
    step(); #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h55 || bus.res_err !== 2'b00 || bus.res_id !== 1'b1) begin errors++; $display("FAIL rcapt_result got=%b %h/%b/%b exp=1 00000055/00/1", bus.res_valid, bus.res_data, bus.res_err, bus.res_id); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_syn = '0; bus.req0_mod = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_syn = '0; bus.req1_mod = '0;
    bus.res_ready = 1'b1;
    bus.cnt_clr = 1'b0;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back_backpressure();
    test_illegal_mode();
    test_saturation_clear();
    test_reset_in_capt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
